// File: rtl/mlp4_pkg.sv
// Shared types and constants for the mlp4 product-accumulate slice.
package mlp4_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } mlp4_acc_state_t;

    localparam int PROD_W   = 8;
    localparam int PROD_MAX = 225;

endpackage

// File: rtl/mlp4_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with carry out.
// Build option MLP4_ACC_SAT_EN clamps the sum to all-ones on carry instead of wrapping.
module mlp4_acc_add
    import mlp4_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw;

`ifdef MLP4_ACC_SAT_EN
    // Once clamped at all-ones, any further non-zero product carries again, so the clamp holds.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] v);
        return v[ACC_W] ? {ACC_W{1'b1}} : v[ACC_W-1:0];
    endfunction
`endif

    always_comb begin
        raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = raw[ACC_W];
`ifdef MLP4_ACC_SAT_EN
        sum   = sat_clamp(raw);
`else
        sum   = raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mlp4_dot_acc.sv
// Dot-product accumulator behind the 4x4 multiplier PLA: sums LEN products (or up to in_last)
// and holds the result on a valid/ready output. Optional build macro: MLP4_ACC_SAT_EN.
module mlp4_dot_acc
    import mlp4_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 10,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    mlp4_acc_state_t  state;
    logic [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             ovf_p0;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             close;

    mlp4_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc   (acc_p0),
        .prod  (in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign cnt_inc   = cnt_p0 + CNT_W'(1);
    // A last flag on the LEN-th beat still yields exactly one close.
    assign close     = accept & ((cnt_inc == LEN_C) | in_last);

    // Accumulate stage -> result hold stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc_p0    <= '0;
            cnt_p0    <= '0;
            ovf_p0    <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (close) begin
                        out_sum   <= add_sum;
                        out_count <= cnt_inc;
                        out_ovf   <= ovf_p0 | add_carry;
                        acc_p0    <= '0;
                        cnt_p0    <= '0;
                        ovf_p0    <= 1'b0;
                        state     <= HOLD;
                    end else if (accept) begin
                        acc_p0    <= add_sum;
                        cnt_p0    <= cnt_inc;
                        ovf_p0    <= ovf_p0 | add_carry;
                    end
                end
                HOLD: begin
                    // No bypass: in_ready stays low on the transfer edge.
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
